// File: rtl/mem_burst_master.sv
// Burst request engine: turns one (direction, address, length) command into a
// sequence of single-word valid/ready memory transactions, streaming data in or out.
module mem_burst_master #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic                  rdata_valid_o,
    input  logic                  rdata_ready_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic                  mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic [WIDTH-1:0]      mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        WR_REQ  = 3'd2,
        RD_REQ  = 3'd3,
        RD_OUT  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  last_word;

    // Explicit wrap so non-power-of-two depths still stay in range.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        if (a == ADDR_WIDTH'(DEPTH - 1)) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    assign last_word = (cnt_q == LEN_WIDTH'(1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    addr_d = cmd_addr_i;
                    cnt_d  = cmd_len_i;
                    if (cmd_len_i == '0) begin
                        state_d = DONE;
                    end else if (cmd_wr_i) begin
                        state_d = WR_WAIT;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            WR_WAIT: begin
                if (wdata_valid_i) begin
                    wdata_d = wdata_i;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (mem_ready_i) begin
                    addr_d  = next_addr(addr_q);
                    cnt_d   = cnt_q - 1'b1;
                    state_d = last_word ? DONE : WR_WAIT;
                end
            end
            RD_REQ: begin
                if (mem_ready_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = RD_OUT;
                end
            end
            RD_OUT: begin
                if (rdata_ready_i) begin
                    addr_d  = next_addr(addr_q);
                    cnt_d   = cnt_q - 1'b1;
                    state_d = last_word ? DONE : RD_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from state so an asynchronous reset clears them at once.
    assign cmd_ready_o   = (state_q == IDLE);
    assign wdata_ready_o = (state_q == WR_WAIT);
    assign rdata_valid_o = (state_q == RD_OUT);
    assign rdata_o       = rdata_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign mem_valid_o   = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign mem_wr_rd_o   = (state_q == WR_REQ);
    assign mem_addr_o    = mem_valid_o ? addr_q : '0;
    assign mem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Randomized bench for mem_burst_master: acts as the memory, streams write data,
// consumes read data and compares everything against a word-level burst model.
module tb_mem_burst_master;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LW    = 7;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             cmd_valid_i, cmd_ready_o, cmd_wr_i;
    logic [AW-1:0]    cmd_addr_i;
    logic [LW-1:0]    cmd_len_i;
    logic             wdata_valid_i, wdata_ready_o;
    logic [WIDTH-1:0] wdata_i;
    logic             rdata_valid_o, rdata_ready_i;
    logic [WIDTH-1:0] rdata_o;
    logic             busy_o, done_o;
    logic             mem_valid_o, mem_ready_i, mem_wr_rd_o;
    logic [AW-1:0]    mem_addr_o;
    logic [WIDTH-1:0] mem_wdata_o, mem_rdata_i;

    logic [WIDTH-1:0] tb_mem [DEPTH];
    logic [WIDTH-1:0] ref_mem[DEPTH];
    logic [WIDTH-1:0] wq[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_rdata_i = tb_mem[mem_addr_o];

    mem_burst_master #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
        .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
        .busy_o(busy_o), .done_o(done_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_wr_rd_o(mem_wr_rd_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid_i   = 1'b0;
        cmd_wr_i      = 1'b0;
        cmd_addr_i    = '0;
        cmd_len_i     = '0;
        wdata_valid_i = 1'b0;
        wdata_i       = '0;
        rdata_ready_i = 1'b0;
        mem_ready_i   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_rdy"}, 32'(cmd_ready_o), 32'd1);
        check_eq({tag, "_wrdy"}, 32'(wdata_ready_o), 32'd0);
        check_eq({tag, "_rvld"}, 32'(rdata_valid_o), 32'd0);
        check_eq({tag, "_rdata"}, 32'(rdata_o), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_done"}, 32'(done_o), 32'd0);
        check_eq({tag, "_mvld"}, 32'(mem_valid_o), 32'd0);
        check_eq({tag, "_mwr"}, 32'(mem_wr_rd_o), 32'd0);
        check_eq({tag, "_maddr"}, 32'(mem_addr_o), 32'd0);
        check_eq({tag, "_mwdata"}, 32'(mem_wdata_o), 32'd0);
    endtask

    // mode 0: no stalls, 1: random stalls, 2: 3-cycle rdata stall on word 1
    // plus 2-cycle memory stall on word 3. abort_at >= 0 resets during that word's request.
    task automatic run_burst(input bit wr, input int a, input int len, input int mode,
                             input int abort_at);
        logic [WIDTH-1:0] d[$];
        logic [AW-1:0]    prev_addr;
        logic [WIDTH-1:0] prev_wd, prev_rd;
        bit               prev_mstall, prev_rstall, done_seen;
        int               stalls, widx, mh, ridx, rd_st, mem_st, e;
        for (int i = 0; i < len; i++) begin
            if (wr && i < wq.size()) d.push_back(wq[i]);
            else d.push_back(WIDTH'($urandom));
        end
        wq.delete();
        stalls = 0; widx = 0; mh = 0; ridx = 0; rd_st = 0; mem_st = 0;
        prev_mstall = 0; prev_rstall = 0; done_seen = 0;
        prev_addr = '0; prev_wd = '0; prev_rd = '0;

        cmd_valid_i = 1'b1;
        cmd_wr_i    = wr;
        cmd_addr_i  = AW'(a);
        cmd_len_i   = LW'(len);
        @(negedge clk);
        check_eq("cmd_accept", 32'(cmd_ready_o), 32'd1);
        @(posedge clk); #1;

        for (int cyc = 1; cyc <= 2000; cyc++) begin
            cmd_valid_i = (cyc == 2) || (mode == 1 && $urandom_range(0, 7) == 0);
            cmd_wr_i    = 1'($urandom);
            cmd_addr_i  = AW'($urandom);
            cmd_len_i   = LW'($urandom_range(1, 9));
            wdata_valid_i = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdata_i       = (widx < len) ? d[widx] : WIDTH'($urandom);
            if (mode == 1) begin
                mem_ready_i   = ($urandom_range(0, 3) != 0);
                rdata_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                mem_ready_i   = !(mode == 2 && ridx == 3 && mem_st < 2);
                rdata_ready_i = !(mode == 2 && ridx == 1 && rd_st < 3);
            end
            @(negedge clk);

            if (abort_at >= 0 && mem_valid_o && mh == abort_at) begin
                rst_i = 1'b0;
                #1;
                check_reset_outputs("rst_mid");
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_eq("rst_no_done", 32'(done_o), 32'd0);
                    check_eq("rst_hold_mvld", 32'(mem_valid_o), 32'd0);
                end
                idle_inputs();
                rst_i = 1'b1;
                @(posedge clk); #1;
                return;
            end

            check_eq("busy", 32'(busy_o), 32'd1);
            check_eq("cmd_rdy_busy", 32'(cmd_ready_o), 32'd0);
            if (!mem_valid_o) begin
                check_eq("idle_maddr", 32'(mem_addr_o), 32'd0);
                check_eq("idle_mwr", 32'(mem_wr_rd_o), 32'd0);
            end
            if (prev_mstall) begin
                check_eq("stall_mvld", 32'(mem_valid_o), 32'd1);
                check_eq("stall_maddr", 32'(mem_addr_o), 32'(prev_addr));
                if (wr) check_eq("stall_mwdata", 32'(mem_wdata_o), 32'(prev_wd));
            end
            if (prev_rstall) begin
                check_eq("stall_rvld", 32'(rdata_valid_o), 32'd1);
                check_eq("stall_rdata", 32'(rdata_o), 32'(prev_rd));
            end

            if (done_o) begin
                check_eq("done_lat", 32'(cyc), 32'(2 * len + 1 + stalls));
                if (mode == 2) check_eq("bp_stalls", 32'(stalls), 32'd5);
                check_eq("mem_words", 32'(mh), 32'(len));
                check_eq("stream_words", 32'(wr ? widx : ridx), 32'(len));
                done_seen = 1;
                break;
            end

            if (mem_valid_o) begin
                check_eq("dir", 32'(mem_wr_rd_o), 32'(wr));
                if (mem_ready_i) begin
                    if (mh < len) begin
                        e = (a + mh) % DEPTH;
                        check_eq("maddr", 32'(mem_addr_o), 32'(e));
                        if (wr) begin
                            check_eq("mwdata", 32'(mem_wdata_o), 32'(d[mh]));
                            ref_mem[e] = d[mh];
                            tb_mem[mem_addr_o] = mem_wdata_o;
                        end
                    end else begin
                        check_eq("mem_overrun", 32'(mh), 32'(len - 1));
                    end
                    mh++;
                end else begin
                    stalls++;
                    mem_st++;
                end
            end
            if (wdata_ready_o) begin
                check_eq("wrdy_dir", 32'(wr), 32'd1);
                if (wdata_valid_i) widx++;
                else stalls++;
            end
            if (rdata_valid_o) begin
                check_eq("rvld_dir", 32'(wr), 32'd0);
                if (rdata_ready_i) begin
                    if (ridx < len) check_eq("rdata", 32'(rdata_o), 32'(ref_mem[(a + ridx) % DEPTH]));
                    else check_eq("rd_overrun", 32'(ridx), 32'(len - 1));
                    ridx++;
                end else begin
                    stalls++;
                    rd_st++;
                end
            end
            prev_mstall = mem_valid_o && !mem_ready_i;
            prev_addr   = mem_addr_o;
            prev_wd     = mem_wdata_o;
            prev_rstall = rdata_valid_o && !rdata_ready_i;
            prev_rd     = rdata_o;
            @(posedge clk); #1;
        end

        if (!done_seen) check_eq("timeout", 32'(done_seen), 32'd1);
        idle_inputs();
        @(negedge clk);
        check_eq("done_once", 32'(done_o), 32'd0);
        check_eq("post_busy", 32'(busy_o), 32'd0);
        check_eq("post_cmd_rdy", 32'(cmd_ready_o), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        idle_inputs();
        rst_i = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_held");
        rst_i = 1'b1;
        @(posedge clk); #1;

        wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        run_burst(1'b1, 'h15, 5, 0, -1);
        run_burst(1'b0, 'h15, 5, 0, -1);
        check_eq("mem_0x15", 32'(tb_mem['h15]), 32'h1111);
        check_eq("mem_0x19", 32'(tb_mem['h19]), 32'h5555);

        run_burst(1'b1, 'h3E, 4, 0, -1);
        run_burst(1'b0, 'h3E, 4, 2, -1);
        run_burst(1'b1, 'h07, 0, 0, -1);
        run_burst(1'b0, 'h20, 0, 0, -1);

        for (int n = 0; n < 20; n++) begin
            run_burst(1'($urandom), $urandom_range(0, DEPTH - 1), $urandom_range(0, 9), 1, -1);
        end
        run_burst(1'b1, $urandom_range(0, DEPTH - 1), 70, 1, -1);
        run_burst(1'b0, $urandom_range(0, DEPTH - 1), 70, 1, -1);

        run_burst(1'b1, 'h30, 5, 0, 2);
        check_eq("abort_word1", 32'(tb_mem['h31]), 32'(ref_mem['h31]));
        run_burst(1'b0, 'h30, 2, 0, -1);
        run_burst(1'b1, 'h10, 3, 1, -1);
        run_burst(1'b0, 'h10, 3, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
